// File: rtl/fifo_frame_writer.sv
// Write-side frame producer for the dual-clock FIFO: header {tag,len}, then payload words.
// Optional parity trailer word (XOR of the payload) is enabled by defining PARITY_TRAILER_EN.
module fifo_frame_writer #(
  parameter int WIDTH = 8,
  parameter int LEN_W = 4,
  parameter int CNT_W = 16
) (
  input  logic                   wclk,
  input  logic                   wrstn,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [WIDTH-LEN_W-1:0] cmd_tag,
  input  logic [LEN_W-1:0]       cmd_len,
  input  logic                   src_valid,
  output logic                   src_ready,
  input  logic [WIDTH-1:0]       src_data,
  input  logic                   wfull,
  output logic                   winc,
  output logic [WIDTH-1:0]       wdata,
  output logic                   busy,
  output logic                   frame_done,
  output logic [CNT_W-1:0]       word_count
);

  localparam int TAG_W = WIDTH - LEN_W;
  localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1'b1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    DATA = 2'd2
`ifdef PARITY_TRAILER_EN
    , TRL = 2'd3
`endif
  } state_t;

  state_t             state_r, state_s;
  logic [TAG_W-1:0]   tag_r;
  logic [LEN_W-1:0]   len_r;
  logic [LEN_W-1:0]   rem_r;
  logic               frame_done_r;
  logic [CNT_W-1:0]   word_count_r;
  logic               winc_s;
  logic               src_ready_s;
  logic [WIDTH-1:0]   wdata_s;
  logic               wr_fire_s;
  logic               load_cmd_s;
  logic               load_rem_s;
  logic               dec_s;
  logic               done_s;

`ifdef PARITY_TRAILER_EN
  logic [WIDTH-1:0]   checksum_r;
  logic               clr_cs_s;

  function automatic logic [WIDTH-1:0] fold_parity(input logic [WIDTH-1:0] acc,
                                                   input logic [WIDTH-1:0] word);
    return acc ^ word;
  endfunction
`endif

  assign wr_fire_s  = winc_s & ~wfull;
  assign winc       = winc_s;
  assign wdata      = wdata_s;
  assign src_ready  = src_ready_s;
  assign cmd_ready  = (state_r == IDLE);
  assign busy       = (state_r != IDLE);
  assign frame_done = frame_done_r;
  assign word_count = word_count_r;

  // Next-state and FIFO/source handshake decode; winc must follow state in the same cycle
  always_comb begin
    state_s     = state_r;
    winc_s      = 1'b0;
    src_ready_s = 1'b0;
    wdata_s     = {WIDTH{1'b0}};
    load_cmd_s  = 1'b0;
    load_rem_s  = 1'b0;
    dec_s       = 1'b0;
    done_s      = 1'b0;
`ifdef PARITY_TRAILER_EN
    clr_cs_s    = 1'b0;
`endif
    case (state_r)
      IDLE: begin
        if (cmd_valid) begin
          load_cmd_s = 1'b1;
          state_s    = HDR;
        end else begin
          state_s    = IDLE;
        end
      end
      HDR: begin
        winc_s  = 1'b1;
        wdata_s = {tag_r, len_r};
        if (!wfull) begin
          if (len_r == {LEN_W{1'b0}}) begin
`ifdef PARITY_TRAILER_EN
            state_s = TRL;
`else
            done_s  = 1'b1;
            state_s = IDLE;
`endif
          end else begin
            load_rem_s = 1'b1;
            state_s    = DATA;
          end
        end else begin
          state_s = HDR;
        end
      end
      DATA: begin
        // src handshake and FIFO write are the same event here
        winc_s      = src_valid;
        src_ready_s = ~wfull;
        wdata_s     = src_data;
        if (src_valid && !wfull) begin
          dec_s = 1'b1;
          if (rem_r == LEN_ONE) begin
`ifdef PARITY_TRAILER_EN
            state_s = TRL;
`else
            done_s  = 1'b1;
            state_s = IDLE;
`endif
          end else begin
            state_s = DATA;
          end
        end else begin
          state_s = DATA;
        end
      end
`ifdef PARITY_TRAILER_EN
      TRL: begin
        winc_s  = 1'b1;
        wdata_s = checksum_r;
        if (!wfull) begin
          done_s   = 1'b1;
          clr_cs_s = 1'b1;
          state_s  = IDLE;
        end else begin
          state_s  = TRL;
        end
      end
`endif
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State, captured command, payload countdown, done pulse and write counter
  always_ff @(posedge wclk or negedge wrstn) begin
    if (!wrstn) begin
      state_r      <= IDLE;
      tag_r        <= {TAG_W{1'b0}};
      len_r        <= {LEN_W{1'b0}};
      rem_r        <= {LEN_W{1'b0}};
      frame_done_r <= 1'b0;
      word_count_r <= {CNT_W{1'b0}};
    end else begin
      state_r      <= state_s;
      frame_done_r <= done_s;
      if (wr_fire_s) begin
        word_count_r <= word_count_r + CNT_W'(1'b1);
      end
      if (load_cmd_s) begin
        tag_r <= cmd_tag;
        len_r <= cmd_len;
      end
      if (load_rem_s) begin
        rem_r <= len_r;
      end else if (dec_s) begin
        rem_r <= rem_r - LEN_ONE;
      end
    end
  end

`ifdef PARITY_TRAILER_EN
  // Running XOR of accepted payload words, cleared when the trailer is written
  always_ff @(posedge wclk or negedge wrstn) begin
    if (!wrstn) begin
      checksum_r <= {WIDTH{1'b0}};
    end else if (clr_cs_s) begin
      checksum_r <= {WIDTH{1'b0}};
    end else if (dec_s) begin
      checksum_r <= fold_parity(checksum_r, src_data);
    end
  end
`endif

endmodule

// File: tb/tb_fifo_frame_writer.sv
// Directed bench for fifo_frame_writer (CNT_W=4 so the word counter wraps within the run).
// Trailer expectations follow PARITY_TRAILER_EN.
module tb_fifo_frame_writer;

`ifdef PARITY_TRAILER_EN
  localparam int T = 1;
`else
  localparam int T = 0;
`endif

  logic       wclk;
  logic       wrstn;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [3:0] cmd_tag;
  logic [3:0] cmd_len;
  logic       src_valid;
  logic       src_ready;
  logic [7:0] src_data;
  logic       wfull;
  logic       winc;
  logic [7:0] wdata;
  logic       busy;
  logic       frame_done;
  logic [3:0] word_count;

  int         n_cmp = 0;
  int         n_err = 0;
  int         done_cnt = 0;
  int         exp_wc = 0;
  int         cyc;
  logic [7:0] cs;
  logic [7:0] pay [16];
  logic [7:0] wr_q [$];
  logic [7:0] exp_q [$];

  fifo_frame_writer #(.WIDTH(8), .LEN_W(4), .CNT_W(4)) dut (
    .wclk       (wclk),
    .wrstn      (wrstn),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_tag    (cmd_tag),
    .cmd_len    (cmd_len),
    .src_valid  (src_valid),
    .src_ready  (src_ready),
    .src_data   (src_data),
    .wfull      (wfull),
    .winc       (winc),
    .wdata      (wdata),
    .busy       (busy),
    .frame_done (frame_done),
    .word_count (word_count)
  );

  initial wclk = 1'b0;
  always #5 wclk = ~wclk;

  // FIFO-side model: record every accepted write and count done pulses
  always @(posedge wclk) begin
    if (wrstn && winc && !wfull) wr_q.push_back(wdata);
    if (wrstn && frame_done) done_cnt++;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_frame(input string tag);
    chk({tag, "_nwords"}, wr_q.size(), exp_q.size());
    for (int i = 0; i < wr_q.size() && i < exp_q.size(); i++)
      chk($sformatf("%s_w%0d", tag, i), wr_q[i], exp_q[i]);
    wr_q.delete();
    exp_q.delete();
  endtask

  // Called at a negedge; returns at the negedge where the DUT is back in IDLE.
  task automatic drive_frame(input logic [3:0] tag, input logic [3:0] len,
                             input logic [63:0] gap, output int cycles);
    int idx;
    bit fire;
    idx = 0;
    cmd_tag = tag;
    cmd_len = len;
    cmd_valid = 1'b1;
    @(negedge wclk);
    cmd_valid = 1'b0;
    cmd_tag = 4'hF;
    cmd_len = 4'hF;
    cycles = 1;
    while (busy && cycles < 64) begin
      src_valid = (idx < int'(len)) && !gap[cycles-1];
      src_data = pay[idx];
      #1;
      fire = src_valid && src_ready;
      @(negedge wclk);
      if (fire) idx++;
      cycles++;
    end
    src_valid = 1'b0;
    chk("frame_timeout", {31'd0, cycles < 64}, 32'd1);
  endtask

  initial begin
    wrstn = 1'b0; cmd_valid = 1'b0; cmd_tag = 4'h0; cmd_len = 4'h0;
    src_valid = 1'b0; src_data = 8'h00; wfull = 1'b0;
    repeat (2) @(negedge wclk);
    #1;
    chk("rst_cmd_ready", cmd_ready, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_winc", winc, 1'b0);
    chk("rst_src_ready", src_ready, 1'b0);
    chk("rst_frame_done", frame_done, 1'b0);
    chk("rst_word_count", word_count, 4'd0);
    @(negedge wclk);
    wrstn = 1'b1;
    @(negedge wclk);

    // Basic frame: tag A, len 3
    pay[0] = 8'h11; pay[1] = 8'h22; pay[2] = 8'h33;
    drive_frame(4'hA, 4'd3, 64'd0, cyc);
    chk("t1_cycles", cyc, 3 + 2 + T);
    chk("t1_frame_done", frame_done, 1'b1);
    exp_q = '{8'hA3, 8'h11, 8'h22, 8'h33};
    if (T != 0) exp_q.push_back(8'h00);
    chk_frame("t1");
    exp_wc += 4 + T;
    chk("t1_word_count", word_count, exp_wc % 16);
    @(negedge wclk);
    #1;
    chk("t1_done_one_cycle", frame_done, 1'b0);
    chk("t1_done_cnt", done_cnt, 1);
    @(negedge wclk);

    // FIFO full during header and once during payload
    wfull = 1'b1; cmd_tag = 4'h2; cmd_len = 4'd1; cmd_valid = 1'b1;
    @(negedge wclk);
    cmd_valid = 1'b0; src_valid = 1'b1; src_data = 8'h5A;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("t2_stall_winc", winc, 1'b1);
      chk("t2_stall_wdata", wdata, 8'h21);
      @(negedge wclk);
    end
    chk("t2_stall_nwrites", wr_q.size(), 0);
    chk("t2_stall_word_count", word_count, exp_wc % 16);
    wfull = 1'b0;
    #1;
    chk("t2_hdr_wdata", wdata, 8'h21);
    @(negedge wclk);
    wfull = 1'b1;
    #1;
    chk("t2_full_src_ready", src_ready, 1'b0);
    chk("t2_full_winc", winc, 1'b1);
    chk("t2_full_wdata", wdata, 8'h5A);
    @(negedge wclk);
    wfull = 1'b0;
    #1;
    chk("t2_src_ready", src_ready, 1'b1);
    @(negedge wclk);
    src_valid = 1'b0;
    if (T != 0) @(negedge wclk);
    chk("t2_frame_done", frame_done, 1'b1);
    exp_q = '{8'h21, 8'h5A};
    if (T != 0) exp_q.push_back(8'h5A);
    chk_frame("t2");
    exp_wc += 2 + T;
    chk("t2_word_count", word_count, exp_wc % 16);

    // len=0, accepted back-to-back in the frame_done cycle
    drive_frame(4'h5, 4'd0, 64'd0, cyc);
    chk("t3_cycles", cyc, 2 + T);
    #1;
    chk("t3_cmd_ready", cmd_ready, 1'b1);
    exp_q = '{8'h50};
    if (T != 0) exp_q.push_back(8'h00);
    chk_frame("t3");
    exp_wc += 1 + T;
    chk("t3_word_count", word_count, exp_wc % 16);

    // Source bubbles, len 4
    pay[0] = 8'h01; pay[1] = 8'h02; pay[2] = 8'h04; pay[3] = 8'h08;
    drive_frame(4'h3, 4'd4, 64'h54, cyc);
    chk("t4_cycles", cyc, 4 + 2 + 3 + T);
    exp_q = '{8'h34, 8'h01, 8'h02, 8'h04, 8'h08};
    if (T != 0) exp_q.push_back(8'h0F);
    chk_frame("t4");
    exp_wc += 5 + T;
    chk("t4_word_count", word_count, exp_wc % 16);

    // Reset after header + 1 payload word of a len 5 frame
    @(negedge wclk);
    cmd_tag = 4'h7; cmd_len = 4'd5; cmd_valid = 1'b1;
    @(negedge wclk);
    cmd_valid = 1'b0; src_valid = 1'b1; src_data = 8'hC1;
    @(negedge wclk);
    @(negedge wclk);
    wrstn = 1'b0;
    #1;
    chk("t5_winc", winc, 1'b0);
    chk("t5_src_ready", src_ready, 1'b0);
    chk("t5_busy", busy, 1'b0);
    chk("t5_cmd_ready", cmd_ready, 1'b1);
    chk("t5_frame_done", frame_done, 1'b0);
    chk("t5_word_count", word_count, 4'd0);
    exp_q = '{8'h75, 8'hC1};
    chk_frame("t5_partial");
    @(negedge wclk);
    wrstn = 1'b1; src_valid = 1'b0;
    exp_wc = 0;
    @(negedge wclk);
    pay[0] = 8'h3C; pay[1] = 8'hC3;
    drive_frame(4'h9, 4'd2, 64'd0, cyc);
    exp_q = '{8'h92, 8'h3C, 8'hC3};
    if (T != 0) exp_q.push_back(8'hFF);
    chk_frame("t5_next");
    exp_wc += 3 + T;
    chk("t5_next_word_count", word_count, exp_wc % 16);

    // Fill out to 16 words since reset: counter wraps to 0
    cs = 8'h00;
    for (int i = 0; i < 12 - 2 * T; i++) begin
      pay[i] = 8'(i + 1);
      cs = cs ^ pay[i];
    end
    drive_frame(4'h1, 4'(12 - 2 * T), 64'd0, cyc);
    chk("t6_cycles", cyc, 12 - 2 * T + 2 + T);
    exp_q = '{8'h1C - 8'(2 * T)};
    for (int i = 0; i < 12 - 2 * T; i++) exp_q.push_back(pay[i]);
    if (T != 0) exp_q.push_back(cs);
    chk_frame("t6");
    exp_wc += 12 - 2 * T + 1 + T;
    chk("t6_exp_total", exp_wc, 16);
    chk("t6_word_count_wrap", word_count, 4'd0);
    @(negedge wclk);
    chk("done_cnt_total", done_cnt, 6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
